pri_request_latch: RTL
======================

# pri_request_latch

Request-capture and service-handshake stage that sits directly upstream of the 16-bit priority encoder. It synchronises 16 asynchronous request lines and latches their rising edges as pending bits. It presents the unmasked pending vector and enable to the encoder, captures the returned 4-bit index, and holds it for a consumer until acknowledged. On acknowledge it clears the serviced pending bit.

## Interface
- SYNC_STAGES, 2, flip-flops in each request synchroniser (legal values 2..3)
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low reset
- req_in  in  16  asynchronous level requests; a rising edge creates one pending event
- mask  in  16  1 = bit blocked from arbitration (still captured into pending)
- encoder_in  out  16  pending & ~mask, combinational from registers, drives encoder
- enable  out  1  encoder enable, high only in state ARB
- binary_out  in  4  encoder result, index of lowest set bit of encoder_in, combinational
- irq  out  1  service request valid
- irq_id  out  4  index being serviced, stable while irq=1
- irq_ack  in  1  consumer acknowledge, sampled only in SERVE
- pending  out  16  raw pending register (status)
- overrun  out  16  sticky: edge arrived on an already-pending bit
- ovf_clr  in  1  clears all overrun bits

## Operation
- Per bit: SYNC_STAGES-flop synchroniser, then a delay flop d. Edge = sync_last & ~d. An edge sets pending[i].
- Edge on a bit already pending, and not being cleared this cycle: overrun[i] <= 1. The event is otherwise dropped.
- FSM states and transitions:
  - IDLE: if |encoder_in, go to ARB; otherwise stay.
  - ARB: enable=1. Unconditionally latch irq_id <= binary_out, set irq <= 1, go to SERVE.
  - SERVE: irq=1. When irq_ack=1, clear pending[irq_id], set irq <= 0, go to IDLE.
- enable is 0 outside ARB. The encoder is never consulted with an all-zero vector.
- Mask changes during SERVE do not affect the index in service.
- irq_ack is ignored in IDLE and ARB.
- Same-cycle new edge and ack-clear on the same bit: set wins, pending stays 1, no overrun.
- ovf_clr and an overrun set on the same bit in the same cycle: set wins.
- Reset: all registers clear, including synchronisers and d.
- Outputs after reset: encoder_in=0, enable=0, irq=0, irq_id=0, pending=0, overrun=0. FSM is in IDLE.
- Reset mid-SERVE drops irq at that edge. The in-flight event is lost.
- A req_in held high through reset re-registers as a new edge after reset deasserts.

## Timing
- req_in rising, stable before edge k:
  - sync_last=1 after edge k+SYNC_STAGES-1
  - pending set at edge k+SYNC_STAGES
- Pending visible at edge E:
  - ARB from E+1 (enable high for exactly one cycle)
  - irq=1 and irq_id valid from E+2
- irq_ack high at edge A (in SERVE):
  - irq=0 and pending bit cleared after A
  - next irq no earlier than A+2
  - minimum service turnaround is 3 cycles including the ack cycle
- irq_ack may be held high continuously. Each SERVE still consumes exactly one ack edge.
- binary_out must settle within the ARB cycle; no extra pipeline stage.

## Test plan
- Reset, then single pulse on req_in[5] (SYNC_STAGES=2) -> pending=0x0020 two edges later; enable pulses one cycle; irq=1, irq_id=5 two edges after pending set; ack -> pending=0, irq=0.
- Simultaneous edges on bits 3, 9 and 0 -> served in order 0, 3, 9; consecutive irq assertions 3 cycles apart with ack held high.
- mask=0x0001 with pending 0x0101 -> irq_id=8; pending[0] retained. Clear mask -> next irq_id=0.
- Second edge on bit 4 while pending[4]=1 and not in service -> overrun=0x0010. ovf_clr -> overrun=0.
- Edge on bit 2 in the same cycle as the ack that clears bit 2 -> pending[2] stays 1, overrun[2]=0, bit 2 served again.
- reset asserted during SERVE with req_in[7] held high -> irq=0 and pending=0 after that edge; after release, pending[7]=1 two edges later and is re-served.

Source files
------------

// File: rtl/pri_request_latch.sv
// pri_request_latch
// Request-capture and service-handshake stage in front of a 16-bit priority
// encoder. Each request line is synchronised, its rising edges are latched
// as pending bits, the unmasked pending vector is offered to the encoder,
// and the returned index is held for a consumer until acknowledged.
//
// Handshake: irq is a valid flag and irq_ack its ready. A transfer happens
// on a rising clock edge where irq=1 and irq_ack=1 (FSM in SERVE). irq_id is
// stable for the whole time irq=1. irq_ack outside SERVE has no effect, and
// a held-high irq_ack completes exactly one transfer per SERVE visit.
//
// SYNC_STAGES is meant to be 2 or 3.

module pri_request_latch #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] req_in,
    input  logic [15:0] mask,
    output logic [15:0] encoder_in,
    output logic        enable,
    input  logic [3:0]  binary_out,
    output logic        irq,
    output logic [3:0]  irq_id,
    input  logic        irq_ack,
    output logic [15:0] pending,
    output logic [15:0] overrun,
    input  logic        ovf_clr,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_SERVE = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] sync_q [SYNC_STAGES];
    logic [15:0] d_q;
    logic [15:0] pending_q;
    logic [15:0] overrun_q;
    logic        irq_q;
    logic [3:0]  irq_id_q;

    logic [15:0] sync_last;
    logic [15:0] edge_vec;
    logic [15:0] clear_vec;
    logic [15:0] ovr_set;
    logic        ack_take;

    assign sync_last = sync_q[SYNC_STAGES-1];

    // One-cycle pulse per request line on a synchronised low-to-high change.
    assign edge_vec = sync_last & ~d_q;

    // A completed handshake retires the bit currently in service.
    assign ack_take = (state_q == S_SERVE) && irq_ack;

    // One-hot of the serviced bit, only in the cycle the ack is taken.
    always_comb begin
        clear_vec = '0;
        if (ack_take) begin
            clear_vec = 16'(1) << irq_id_q;
        end
    end

    // Edge on a bit that stays pending this cycle is a lost event. An edge
    // coinciding with the clear of the same bit simply re-arms it instead.
    assign ovr_set = edge_vec & pending_q & ~clear_vec;

    // Request synchroniser chain and edge-detect delay flop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            d_q <= '0;
        end else begin
            sync_q[0] <= req_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            d_q <= sync_last;
        end
    end

    // Pending bits: set by edges, cleared by the ack; set has priority.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clear_vec) | edge_vec;
        end
    end

    // Sticky overrun flags; a new overrun beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overrun_q <= '0;
        end else if (ovf_clr) begin
            overrun_q <= ovr_set;
        end else begin
            overrun_q <= overrun_q | ovr_set;
        end
    end

    // Service FSM with registered irq and irq_id.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            irq_q    <= 1'b0;
            irq_id_q <= 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Only consult the encoder when something is eligible.
                    if (|encoder_in) begin
                        state_q <= S_ARB;
                    end
                end
                S_ARB: begin
                    // Encoder settles combinationally within this cycle.
                    irq_id_q <= binary_out;
                    irq_q    <= 1'b1;
                    state_q  <= S_SERVE;
                end
                S_SERVE: begin
                    if (irq_ack) begin
                        irq_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    irq_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign encoder_in = pending_q & ~mask;
    assign enable     = (state_q == S_ARB);
    assign irq        = irq_q;
    assign irq_id     = irq_id_q;
    assign pending    = pending_q;
    assign overrun    = overrun_q;
    assign state_dbg  = state_q;

endmodule
